// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and controller state encoding.
package mdu_defs_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// div0 flags a zero divisor so the sequencer can suppress the commit.
module mdu_arith
  import mdu_defs_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa    = $signed(a);
  assign sb    = $signed(b);
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'b0, a} * {32'b0, b};

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    div0   = 1'b0;
    unique case (op_t'(op))
      OP_MULT:  {hi_res, lo_res} = sprod;
      OP_MULTU: {hi_res, lo_res} = uprod;
      OP_DIV: begin
        if (b == 32'b0) begin
          div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // -2^31 / -1 overflows; wrap the quotient and keep a zero remainder
          lo_res = 32'h8000_0000;
          hi_res = 32'b0;
        end else begin
          lo_res = $unsigned(sa / sb);
          hi_res = $unsigned(sa % sb);
        end
      end
      OP_DIVU: begin
        if (b == 32'b0) begin
          div0 = 1'b1;
        end else begin
          lo_res = a / b;
          hi_res = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO sequencer: result computed at issue, committed to
// HI/LO after the configured latency, with pipeline stall generation.
//
//   state  | meaning
//   IDLE   | no op in flight; accepts start or mthi/mtlo writes
//   RUN    | op in flight; cnt counts down to commit
module mdu_ctrl
  import mdu_defs_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_div0;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_div0;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi_res (arith_hi),
    .lo_res (arith_lo),
    .div0   (arith_div0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_div0 <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            res_hi   <= arith_hi;
            res_lo   <= arith_lo;
            res_div0 <= arith_div0;
            cnt      <= op[1] ? DIV_LOAD : MULT_LOAD;
            state    <= S_RUN;
          end else if (mt_we) begin
            if (mt_sel) hi <= mt_data;
            else        lo <= mt_data;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            // a zero divisor runs the full latency but leaves HI/LO alone
            if (!res_div0) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state == S_RUN);
  assign stall = d_uses_md & (busy | start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a longint
// arithmetic reference model with an op-latency countdown.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mt_we;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic        d_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;

  // reference model state
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_div0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .mt_we     (mt_we),
    .mt_sel    (mt_sel),
    .mt_data   (mt_data),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic void ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic z);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rh = '0;
    rl = '0;
    z  = 1'b0;
    case (o)
      2'd0: begin q = sx * sy; rh = q[63:32]; rl = q[31:0]; end
      2'd1: begin uq = ux * uy; rh = uq[63:32]; rl = uq[31:0]; end
      2'd2: begin
        if (y == 32'b0) z = 1'b1;
        else begin
          q = sx / sy; r = sx - q * sy;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      default: begin
        if (y == 32'b0) z = 1'b1;
        else begin
          uq = ux / uy; ur = ux - uq * uy;
          rl = uq[31:0]; rh = ur[31:0];
        end
      end
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_div0 = 1'b0;
  endtask

  // one clock cycle: drive after a negedge, check stall, clock, check state
  task automatic cyc(input logic st, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic mw, input logic ms, input logic [31:0] md, input logic du);
    logic [31:0] eh, el;
    logic        ez;
    start = st; op = o; a = x; b = y;
    mt_we = mw; mt_sel = ms; mt_data = md; d_uses_md = du;
    #1;
    check("stall", {31'b0, stall}, {31'b0, du & ((m_left > 0) | st)});
    @(posedge clk);
    if (m_left == 0) begin
      if (st) begin
        ref_calc(o, x, y, eh, el, ez);
        m_phi = eh; m_plo = el; m_div0 = ez;
        m_left = o[1] ? DIV_N : MULT_N;
      end else if (mw) begin
        if (ms) m_hi = md;
        else    m_lo = md;
      end
    end else begin
      m_left--;
      if (m_left == 0 && !m_div0) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end
    #1;
    check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    start = 1'b0; mt_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic du);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, du);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0; d_uses_md = 1'b1;
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mult -2*3, multu 0xFFFFFFFF*2
    cyc(1'b1, 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(6, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    cyc(1'b1, 2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(6, 1'b0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7/2, then divu by zero leaves HI/LO alone
    cyc(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(11, 1'b0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    cyc(1'b1, 2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(11, 1'b0);
    check("divu0_lo", lo, 32'hFFFF_FFFD);
    check("divu0_hi", hi, 32'hFFFF_FFFF);

    // signed overflow case
    cyc(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(11, 1'b0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);

    // mtlo / mthi in idle
    cyc(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_0055, 1'b0);
    cyc(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0066, 1'b0);
    check("mt_lo", lo, 32'h0000_0055);
    check("mt_hi", hi, 32'h0000_0066);

    // stall through a div, mt_we during RUN ignored
    cyc(1'b1, 2'd2, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(4, 1'b1);
    cyc(1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0000_1234, 1'b1);
    cyc(1'b1, 2'd1, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(6, 1'b1);
    check("div_stall_lo", lo, 32'd14);
    check("div_stall_hi", hi, 32'd2);

    // start wins over same-cycle mt_we
    cyc(1'b1, 2'd0, 32'd2, 32'd3, 1'b1, 1'b1, 32'h0000_AAAA, 1'b0);
    idle(6, 1'b0);
    check("race_hi", hi, 32'd0);
    check("race_lo", lo, 32'd6);

    // async reset in cycle 3 of a div
    cyc(1'b1, 2'd2, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 2'd0, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 1'b0);
    idle(6, 1'b0);
    check("post_rst_lo", lo, 32'd20);
    check("post_rst_hi", hi, 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] x, y;
      x = pick_operand();
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
      cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), x, y,
          ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL expose the parameter MULT_CYCLES, default 5: the number of busy cycles for mult and multu.
REQ-002 The block SHALL expose the parameter DIV_CYCLES, default 10: the number of busy cycles for div and divu.
REQ-003 The block SHALL have these ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  an E-stage mult/multu/div/divu issues this cycle.
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled when start=1.
- a  in  32  E-stage rs operand, already forwarded.
- b  in  32  E-stage rt operand, already forwarded.
- mt_we  in  1  E-stage mthi/mtlo write request.
- mt_sel  in  1  target of mt_we: 0 LO, 1 HI.
- mt_data  in  32  data for mt_we.
- d_uses_md  in  1  the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  an operation is in flight.
- stall  out  1  freeze PC and IF/ID, and insert a bubble into ID/EX.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Function
REQ-004 The block SHALL implement a two-state FSM with states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-005 In IDLE with start=1, the block SHALL capture the full result in internal registers res_hi/res_lo, load cnt with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1), and enter RUN.
REQ-006 In RUN, cnt SHALL decrement by one per cycle. At the edge where cnt==1, res_hi/res_lo SHALL be committed to hi/lo and the FSM SHALL return to IDLE.
REQ-007 busy SHALL equal (state==RUN). For start sampled at edge k, busy SHALL be high for exactly N cycles after k, and the new hi/lo SHALL be visible in the first cycle with busy=0.
REQ-008 mult SHALL compute the signed 64-bit product of a and b; multu SHALL compute the unsigned product. The product is split {hi,lo} = product[63:32], product[31:0].
REQ-009 div SHALL produce a signed quotient in lo and remainder in hi. The remainder takes the sign of the dividend; the quotient truncates toward zero.
REQ-010 divu SHALL produce an unsigned quotient in lo and remainder in hi.
REQ-011 div/divu with b==0 SHALL still run the full DIV_CYCLES, and SHALL leave hi and lo unchanged at completion.
REQ-012 div with a=0x80000000 and b=0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0.
REQ-013 mt_we=1 in IDLE with start=0 SHALL write mt_data into the register selected by mt_sel at the next edge; the other register SHALL be unchanged.
REQ-014 If start and mt_we are both high in the same cycle, start SHALL be taken and mt_we SHALL be ignored.
REQ-015 start or mt_we asserted while in RUN SHALL be ignored. The FSM, cnt and pending result SHALL be unaffected.
REQ-016 stall SHALL be combinational: stall = d_uses_md & (busy | start).
REQ-017 hi and lo SHALL change only on commit (REQ-006) or on an mt write (REQ-013).

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, cnt=0, busy=0, hi=0, lo=0, res_hi=0, res_lo=0.
REQ-019 A reset during RUN SHALL discard the pending result. After rst_n rises, the block SHALL be in IDLE and accept start on the first clock edge.

Structure
REQ-020 The op encodings, MULT_CYCLES/DIV_CYCLES defaults and state encodings SHALL live in the shared mdu_defs include file.
REQ-021 Result computation SHALL be a purely combinational sub-module, mdu_arith (inputs op, a, b; outputs hi_res, lo_res, div0). The sequencing logic SHALL remain in mdu_ctrl.

Verification
REQ-022 mult with a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-023 multu with a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-024 div with a=-7, b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu with a=7, b=0 -> hi/lo unchanged after 10 cycles.
REQ-025 Issue div, then hold d_uses_md=1 -> stall=1 in the start cycle and for all 10 busy cycles, and stall=0 in the cycle busy falls. An mt_we pulse with 0x1234 during RUN is ignored.
REQ-026 Same-cycle start (mult 2*3) and mt_we (HI=0xAAAA) -> hi=0, lo=6. Separately, pull rst_n low in cycle 3 of a div -> busy=0, hi=lo=0 immediately, and a new mult issued after release completes normally.
